// File: rtl/tcdm_reorder_shim.sv
// Reorder shim between a single in-order core data port and NrTCDM banked TCDM ports.
// Requests fan out by address; out-of-order TCDM responses are returned to the core in request order.
module tcdm_reorder_shim #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NrTCDM    = 4,
  parameter int unsigned SelOffset = 2,
  parameter int unsigned RobDepth  = 8,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned SelWidth  = (NrTCDM > 1) ? $clog2(NrTCDM) : 1,
  localparam int unsigned IdWidth   = (RobDepth > 1) ? $clog2(RobDepth) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // core request
  input  logic [AddrWidth-1:0] data_qaddr_i,
  input  logic                 data_qwrite_i,
  input  logic [DataWidth-1:0] data_qdata_i,
  input  logic [StrbWidth-1:0] data_qstrb_i,
  input  logic                 data_qvalid_i,
  output logic                 data_qready_o,
  // core response
  output logic [DataWidth-1:0] data_pdata_o,
  output logic                 data_pwrite_o,
  output logic                 data_pvalid_o,
  input  logic                 data_pready_i,
  // TCDM request
  output logic [NrTCDM-1:0]    tcdm_req_valid_o,
  output logic [AddrWidth-1:0] tcdm_req_tgt_addr_o [NrTCDM],
  output logic [NrTCDM-1:0]    tcdm_req_wen_o,
  output logic [DataWidth-1:0] tcdm_req_wdata_o    [NrTCDM],
  output logic [StrbWidth-1:0] tcdm_req_be_o       [NrTCDM],
  output logic [IdWidth-1:0]   tcdm_req_id_o       [NrTCDM],
  input  logic [NrTCDM-1:0]    tcdm_req_ready_i,
  // TCDM response
  input  logic [NrTCDM-1:0]    tcdm_resp_valid_i,
  input  logic [DataWidth-1:0] tcdm_resp_rdata_i   [NrTCDM],
  input  logic [IdWidth-1:0]   tcdm_resp_id_i      [NrTCDM],
  output logic [NrTCDM-1:0]    tcdm_resp_ready_o
);

  localparam int unsigned CntWidth = IdWidth + 1;
  localparam logic [CntWidth-1:0] FullCount = CntWidth'(RobDepth);

  if ((NrTCDM < 2) || ((NrTCDM & (NrTCDM - 1)) != 0)) begin : g_bad_nrtcdm
    $fatal(1, "tcdm_reorder_shim: NrTCDM must be a power of two >= 2");
  end
  if ((RobDepth < 1) || ((RobDepth & (RobDepth - 1)) != 0)) begin : g_bad_robdepth
    $fatal(1, "tcdm_reorder_shim: RobDepth must be a power of two");
  end
  if ((DataWidth % 8) != 0) begin : g_bad_datawidth
    $fatal(1, "tcdm_reorder_shim: DataWidth must be a multiple of 8");
  end

  logic [IdWidth-1:0]   r_head;
  logic [IdWidth-1:0]   r_tail;
  logic [CntWidth-1:0]  r_count;
  logic [RobDepth-1:0]  r_pending;
  logic [RobDepth-1:0]  r_done;
  logic [RobDepth-1:0]  r_write;
  logic [DataWidth-1:0] r_data [RobDepth];

  logic [SelWidth-1:0]  w_sel;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_pop;

  assign w_sel    = data_qaddr_i[SelOffset +: SelWidth];
  // Fullness uses the registered count only, so a same-cycle pop never frees a slot early.
  assign w_full   = (r_count == FullCount);
  assign w_accept = data_qvalid_i & ~w_full & tcdm_req_ready_i[w_sel];
  assign w_pop    = r_done[r_head] & data_pready_i;

  assign data_qready_o = ~w_full & tcdm_req_ready_i[w_sel];
  assign data_pvalid_o = r_done[r_head];
  assign data_pdata_o  = r_data[r_head];
  assign data_pwrite_o = r_write[r_head];

  for (genvar gi = 0; gi < NrTCDM; gi++) begin : g_port
    assign tcdm_req_valid_o[gi]    = data_qvalid_i & ~w_full & (w_sel == SelWidth'(gi));
    assign tcdm_req_tgt_addr_o[gi] = data_qaddr_i;
    assign tcdm_req_wen_o[gi]      = data_qwrite_i;
    assign tcdm_req_wdata_o[gi]    = data_qdata_i;
    assign tcdm_req_be_o[gi]       = data_qstrb_i;
    assign tcdm_req_id_o[gi]       = r_tail;
    assign tcdm_resp_ready_o[gi]   = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_done    <= '0;
      r_write   <= '0;
    end else begin
      if (w_accept) begin
        r_pending[r_tail] <= 1'b1;
        r_write[r_tail]   <= data_qwrite_i;
        r_tail            <= r_tail + IdWidth'(1);
      end
      if (w_pop) begin
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + IdWidth'(1);
      end
      // Stale responses (e.g. from before a reset) hit non-pending entries and are dropped.
      for (int p = 0; p < NrTCDM; p++) begin
        if (tcdm_resp_valid_i[p] && r_pending[tcdm_resp_id_i[p]]) begin
          r_done[tcdm_resp_id_i[p]]    <= 1'b1;
          r_pending[tcdm_resp_id_i[p]] <= 1'b0;
        end
      end
      r_count <= r_count + CntWidth'(w_accept) - CntWidth'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrTCDM; p++) begin
      if (tcdm_resp_valid_i[p] && r_pending[tcdm_resp_id_i[p]]) begin
        r_data[tcdm_resp_id_i[p]] <= tcdm_resp_rdata_i[p];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int p = 0; p < NrTCDM; p++) begin
        if (tcdm_resp_valid_i[p]) begin
          assert (r_pending[tcdm_resp_id_i[p]])
            else $error("tcdm_reorder_shim: response on port %0d with non-pending id %0d", p, tcdm_resp_id_i[p]);
        end
        for (int q = p + 1; q < NrTCDM; q++) begin
          if (tcdm_resp_valid_i[p] && tcdm_resp_valid_i[q]) begin
            assert (tcdm_resp_id_i[p] != tcdm_resp_id_i[q])
              else $error("tcdm_reorder_shim: ports %0d and %0d respond with equal id %0d", p, q, tcdm_resp_id_i[p]);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_reorder_shim.sv
// Directed self-checking bench for tcdm_reorder_shim with default parameters.
// Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
module tb_tcdm_reorder_shim;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] data_qaddr_i;
  logic        data_qwrite_i;
  logic [31:0] data_qdata_i;
  logic [3:0]  data_qstrb_i;
  logic        data_qvalid_i;
  logic        data_qready_o;
  logic [31:0] data_pdata_o;
  logic        data_pwrite_o;
  logic        data_pvalid_o;
  logic        data_pready_i;
  logic [3:0]  tcdm_req_valid_o;
  logic [31:0] tcdm_req_tgt_addr_o [4];
  logic [3:0]  tcdm_req_wen_o;
  logic [31:0] tcdm_req_wdata_o [4];
  logic [3:0]  tcdm_req_be_o [4];
  logic [2:0]  tcdm_req_id_o [4];
  logic [3:0]  tcdm_req_ready_i;
  logic [3:0]  tcdm_resp_valid_i;
  logic [31:0] tcdm_resp_rdata_i [4];
  logic [2:0]  tcdm_resp_id_i [4];
  logic [3:0]  tcdm_resp_ready_o;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  exp_tail;

  always #5 clk_i = ~clk_i;

  tcdm_reorder_shim dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .data_qaddr_i        (data_qaddr_i),
    .data_qwrite_i       (data_qwrite_i),
    .data_qdata_i        (data_qdata_i),
    .data_qstrb_i        (data_qstrb_i),
    .data_qvalid_i       (data_qvalid_i),
    .data_qready_o       (data_qready_o),
    .data_pdata_o        (data_pdata_o),
    .data_pwrite_o       (data_pwrite_o),
    .data_pvalid_o       (data_pvalid_o),
    .data_pready_i       (data_pready_i),
    .tcdm_req_valid_o    (tcdm_req_valid_o),
    .tcdm_req_tgt_addr_o (tcdm_req_tgt_addr_o),
    .tcdm_req_wen_o      (tcdm_req_wen_o),
    .tcdm_req_wdata_o    (tcdm_req_wdata_o),
    .tcdm_req_be_o       (tcdm_req_be_o),
    .tcdm_req_id_o       (tcdm_req_id_o),
    .tcdm_req_ready_i    (tcdm_req_ready_i),
    .tcdm_resp_valid_i   (tcdm_resp_valid_i),
    .tcdm_resp_rdata_i   (tcdm_resp_rdata_i),
    .tcdm_resp_id_i      (tcdm_resp_id_i),
    .tcdm_resp_ready_o   (tcdm_resp_ready_o)
  );

  task automatic clear_req();
    data_qvalid_i = 1'b0;
    data_qwrite_i = 1'b0;
    data_qaddr_i  = '0;
    data_qdata_i  = '0;
    data_qstrb_i  = '0;
  endtask

  task automatic clear_resp();
    for (int p = 0; p < 4; p++) begin
      tcdm_resp_valid_i[p] = 1'b0;
      tcdm_resp_id_i[p]    = '0;
      tcdm_resp_rdata_i[p] = '0;
    end
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata, input logic [3:0] strb);
    data_qaddr_i  = addr;
    data_qwrite_i = wr;
    data_qdata_i  = wdata;
    data_qstrb_i  = strb;
    data_qvalid_i = 1'b1;
  endtask

  task automatic drive_resp(input int port, input logic [2:0] id, input logic [31:0] rdata);
    tcdm_resp_valid_i[port] = 1'b1;
    tcdm_resp_id_i[port]    = id;
    tcdm_resp_rdata_i[port] = rdata;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_req();
    clear_resp();
    data_pready_i    = 1'b0;
    tcdm_req_ready_i = 4'hF;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL rst_pvalid got %b exp 0", data_pvalid_o); end
    checks++; if (tcdm_req_valid_o !== 4'b0000) begin errors++; $display("FAIL rst_req_valid got %b exp 0000", tcdm_req_valid_o); end
    checks++; if (tcdm_resp_ready_o !== 4'b1111) begin errors++; $display("FAIL rst_resp_ready got %b exp 1111", tcdm_resp_ready_o); end
    checks++; if (data_qready_o !== 1'b1) begin errors++; $display("FAIL rst_qready got %b exp 1", data_qready_o); end
    @(negedge clk_i);
    rst_ni   = 1'b1;
    exp_tail = 3'd0;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    @(negedge clk_i);
    drive_req(32'h4, 1'b0, 32'h0, 4'h0);
    #1;
    checks++; if (tcdm_req_valid_o !== 4'b0010) begin errors++; $display("FAIL rd_req_valid got %b exp 0010", tcdm_req_valid_o); end
    checks++; if (tcdm_req_id_o[1] !== exp_tail) begin errors++; $display("FAIL rd_req_id got %0d exp %0d", tcdm_req_id_o[1], exp_tail); end
    checks++; if (tcdm_req_tgt_addr_o[3] !== 32'h4) begin errors++; $display("FAIL rd_addr_bcast got %h exp 00000004", tcdm_req_tgt_addr_o[3]); end
    checks++; if (data_qready_o !== 1'b1) begin errors++; $display("FAIL rd_qready got %b exp 1", data_qready_o); end
    exp_tail++;
    @(negedge clk_i);
    clear_req();
    @(negedge clk_i);
    drive_resp(1, 3'd0, 32'hDEADBEEF);
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL rd_pvalid_early got %b exp 0", data_pvalid_o); end
    @(negedge clk_i);
    clear_resp();
    data_pready_i = 1'b1;
    #1;
    checks++; if (data_pvalid_o !== 1'b1) begin errors++; $display("FAIL rd_pvalid got %b exp 1", data_pvalid_o); end
    checks++; if (data_pdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_pdata got %h exp deadbeef", data_pdata_o); end
    checks++; if (data_pwrite_o !== 1'b0) begin errors++; $display("FAIL rd_pwrite got %b exp 0", data_pwrite_o); end
    @(negedge clk_i);
    data_pready_i = 1'b0;
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL rd_pvalid_after_pop got %b exp 0", data_pvalid_o); end
    $display("test_single_read done");
  endtask

  task automatic test_out_of_order();
    @(negedge clk_i);
    drive_req(32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    checks++; if (tcdm_req_valid_o !== 4'b0001) begin errors++; $display("FAIL ooo_a_valid got %b exp 0001", tcdm_req_valid_o); end
    checks++; if (tcdm_req_id_o[0] !== exp_tail) begin errors++; $display("FAIL ooo_a_id got %0d exp %0d", tcdm_req_id_o[0], exp_tail); end
    exp_tail++;
    @(negedge clk_i);
    drive_req(32'h4, 1'b0, 32'h0, 4'h0);
    #1;
    checks++; if (tcdm_req_valid_o !== 4'b0010) begin errors++; $display("FAIL ooo_b_valid got %b exp 0010", tcdm_req_valid_o); end
    checks++; if (tcdm_req_id_o[1] !== exp_tail) begin errors++; $display("FAIL ooo_b_id got %0d exp %0d", tcdm_req_id_o[1], exp_tail); end
    exp_tail++;
    @(negedge clk_i);
    clear_req();
    drive_resp(1, 3'd2, 32'hBBBB0002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      clear_resp();
      #1;
      checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL ooo_wait%0d got %b exp 0", i, data_pvalid_o); end
    end
    drive_resp(0, 3'd1, 32'hAAAA0001);
    @(negedge clk_i);
    clear_resp();
    data_pready_i = 1'b1;
    #1;
    checks++; if (data_pvalid_o !== 1'b1) begin errors++; $display("FAIL ooo_a_pvalid got %b exp 1", data_pvalid_o); end
    checks++; if (data_pdata_o !== 32'hAAAA0001) begin errors++; $display("FAIL ooo_a_pdata got %h exp aaaa0001", data_pdata_o); end
    @(negedge clk_i);
    #1;
    checks++; if (data_pvalid_o !== 1'b1) begin errors++; $display("FAIL ooo_b_pvalid got %b exp 1", data_pvalid_o); end
    checks++; if (data_pdata_o !== 32'hBBBB0002) begin errors++; $display("FAIL ooo_b_pdata got %h exp bbbb0002", data_pdata_o); end
    @(negedge clk_i);
    data_pready_i = 1'b0;
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL ooo_drained got %b exp 0", data_pvalid_o); end
    $display("test_out_of_order done");
  endtask

  task automatic test_write();
    @(negedge clk_i);
    drive_req(32'h8, 1'b1, 32'h123455AA, 4'b0011);
    #1;
    checks++; if (tcdm_req_valid_o !== 4'b0100) begin errors++; $display("FAIL wr_valid got %b exp 0100", tcdm_req_valid_o); end
    checks++; if (tcdm_req_wen_o[2] !== 1'b1) begin errors++; $display("FAIL wr_wen got %b exp 1", tcdm_req_wen_o[2]); end
    checks++; if (tcdm_req_be_o[2] !== 4'b0011) begin errors++; $display("FAIL wr_be got %b exp 0011", tcdm_req_be_o[2]); end
    checks++; if (tcdm_req_wdata_o[0] !== 32'h123455AA) begin errors++; $display("FAIL wr_wdata_bcast got %h exp 123455aa", tcdm_req_wdata_o[0]); end
    checks++; if (tcdm_req_id_o[2] !== exp_tail) begin errors++; $display("FAIL wr_id got %0d exp %0d", tcdm_req_id_o[2], exp_tail); end
    exp_tail++;
    @(negedge clk_i);
    clear_req();
    drive_resp(2, 3'd3, 32'hFFFFFFFF);
    @(negedge clk_i);
    clear_resp();
    #1;
    checks++; if (data_pvalid_o !== 1'b1) begin errors++; $display("FAIL wr_pvalid got %b exp 1", data_pvalid_o); end
    checks++; if (data_pwrite_o !== 1'b1) begin errors++; $display("FAIL wr_pwrite got %b exp 1", data_pwrite_o); end
    @(negedge clk_i);
    #1;
    checks++; if (data_pvalid_o !== 1'b1) begin errors++; $display("FAIL wr_hold_pvalid got %b exp 1", data_pvalid_o); end
    checks++; if (data_pdata_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL wr_hold_pdata got %h exp ffffffff", data_pdata_o); end
    data_pready_i = 1'b1;
    @(negedge clk_i);
    data_pready_i = 1'b0;
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL wr_popped got %b exp 0", data_pvalid_o); end
    $display("test_write done");
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      drive_req(32'(i * 4), 1'b0, 32'h0, 4'h0);
      #1;
      checks++; if (data_qready_o !== 1'b1) begin errors++; $display("FAIL full_fill%0d_qready got %b exp 1", i, data_qready_o); end
      checks++; if (tcdm_req_id_o[0] !== exp_tail) begin errors++; $display("FAIL full_fill%0d_id got %0d exp %0d", i, tcdm_req_id_o[0], exp_tail); end
      exp_tail++;
    end
    // Ninth request while full; oldest entry (id 4) answers in the same cycle.
    @(negedge clk_i);
    drive_req(32'h20, 1'b0, 32'h0, 4'h0);
    drive_resp(0, 3'd4, 32'hC0DE0004);
    #1;
    checks++; if (data_qready_o !== 1'b0) begin errors++; $display("FAIL full_9th_qready got %b exp 0", data_qready_o); end
    checks++; if (tcdm_req_valid_o !== 4'b0000) begin errors++; $display("FAIL full_9th_valid got %b exp 0000", tcdm_req_valid_o); end
    @(negedge clk_i);
    clear_resp();
    data_pready_i = 1'b1;
    #1;
    checks++; if (data_pvalid_o !== 1'b1) begin errors++; $display("FAIL full_pop_pvalid got %b exp 1", data_pvalid_o); end
    checks++; if (data_pdata_o !== 32'hC0DE0004) begin errors++; $display("FAIL full_pop_pdata got %h exp c0de0004", data_pdata_o); end
    checks++; if (data_qready_o !== 1'b0) begin errors++; $display("FAIL full_pop_qready got %b exp 0", data_qready_o); end
    @(negedge clk_i);
    data_pready_i = 1'b0;
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL full_after_pvalid got %b exp 0", data_pvalid_o); end
    checks++; if (data_qready_o !== 1'b1) begin errors++; $display("FAIL full_after_qready got %b exp 1", data_qready_o); end
    checks++; if (tcdm_req_valid_o !== 4'b0001) begin errors++; $display("FAIL full_after_valid got %b exp 0001", tcdm_req_valid_o); end
    checks++; if (tcdm_req_id_o[0] !== exp_tail) begin errors++; $display("FAIL full_after_id got %0d exp %0d", tcdm_req_id_o[0], exp_tail); end
    exp_tail++;
    @(negedge clk_i);
    clear_req();
    #1;
    checks++; if (data_qready_o !== 1'b0) begin errors++; $display("FAIL full_refilled_qready got %b exp 0", data_qready_o); end
    $display("test_full done");
  endtask

  task automatic test_all_ports();
    // Outstanding in order: 5,6,7,0,1,2,3,4.
    @(negedge clk_i);
    for (int p = 0; p < 3; p++) drive_resp(p, 3'(5 + p), 32'h20000005 + 32'(p));
    @(negedge clk_i);
    clear_resp();
    data_pready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (data_pdata_o !== 32'h20000005 + 32'(j) || data_pvalid_o !== 1'b1) begin errors++; $display("FAIL ap_pre%0d got %b/%h exp 1/%h", j, data_pvalid_o, data_pdata_o, 32'h20000005 + 32'(j)); end
      @(negedge clk_i);
    end
    for (int p = 0; p < 4; p++) drive_resp(p, 3'(p), 32'h30000000 + 32'(p));
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL ap_wait got %b exp 0", data_pvalid_o); end
    @(negedge clk_i);
    clear_resp();
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (data_pvalid_o !== 1'b1) begin errors++; $display("FAIL ap_pvalid%0d got %b exp 1", j, data_pvalid_o); end
      checks++; if (data_pdata_o !== 32'h30000000 + 32'(j)) begin errors++; $display("FAIL ap_pdata%0d got %h exp %h", j, data_pdata_o, 32'h30000000 + 32'(j)); end
      @(negedge clk_i);
    end
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL ap_gap got %b exp 0", data_pvalid_o); end
    drive_resp(1, 3'd4, 32'h40000004);
    @(negedge clk_i);
    clear_resp();
    #1;
    checks++; if (data_pdata_o !== 32'h40000004) begin errors++; $display("FAIL ap_last got %h exp 40000004", data_pdata_o); end
    @(negedge clk_i);
    data_pready_i = 1'b0;
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL ap_drained got %b exp 0", data_pvalid_o); end
    $display("test_all_ports done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive_req(32'(i * 4), 1'b0, 32'h0, 4'h0);
      #1;
      checks++; if (tcdm_req_id_o[0] !== exp_tail) begin errors++; $display("FAIL rm_pre_id%0d got %0d exp %0d", i, tcdm_req_id_o[0], exp_tail); end
      exp_tail++;
    end
    @(negedge clk_i);
    clear_req();
    drive_resp(0, 3'd5, 32'h55555555);
    @(negedge clk_i);
    clear_resp();
    #1;
    checks++; if (data_pvalid_o !== 1'b1) begin errors++; $display("FAIL rm_pre_pvalid got %b exp 1", data_pvalid_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (data_pvalid_o !== 1'b0) begin errors++; $display("FAIL rm_async_pvalid got %b exp 0", data_pvalid_o); end
    checks++; if (data_qready_o !== 1'b1) begin errors++; $display("FAIL rm_async_qready got %b exp 1", data_qready_o); end
    @(negedge clk_i);
    rst_ni   = 1'b1;
    exp_tail = 3'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      drive_req(32'(i * 4), 1'b0, 32'h0, 4'h0);
      #1;
      checks++; if (data_qready_o !== 1'b1) begin errors++; $display("FAIL rm_fill%0d_qready got %b exp 1", i, data_qready_o); end
      checks++; if (tcdm_req_id_o[0] !== exp_tail) begin errors++; $display("FAIL rm_fill%0d_id got %0d exp %0d", i, tcdm_req_id_o[0], exp_tail); end
      exp_tail++;
    end
    @(negedge clk_i);
    drive_req(32'h20, 1'b0, 32'h0, 4'h0);
    #1;
    checks++; if (data_qready_o !== 1'b0) begin errors++; $display("FAIL rm_full_qready got %b exp 0", data_qready_o); end
    @(negedge clk_i);
    clear_req();
    $display("test_reset_mid done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_out_of_order();
    test_write();
    test_full();
    test_all_ports();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_reorder_shim.md
TCDM_REORDER_SHIM -- requirements
Module: tcdm_reorder_shim

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, request address width.
REQ-002 SHALL have parameter DataWidth, default 32, data width; StrbWidth = DataWidth/8.
REQ-003 SHALL have parameter NrTCDM, default 4, number of TCDM ports; power of two, >=2.
REQ-004 SHALL have parameter SelOffset, default 2, LSB of the port-select address field; SelWidth = log2(NrTCDM).
REQ-005 SHALL have parameter RobDepth, default 8, reorder-buffer entries; power of two; IdWidth = idx_width(RobDepth).
REQ-006 SHALL have a single clock and an asynchronous active-low reset: clk_i input 1 clock; rst_ni input 1 async active-low reset.
REQ-007 SHALL have core request ports: data_qaddr_i in AddrWidth; data_qwrite_i in 1; data_qdata_i in DataWidth; data_qstrb_i in StrbWidth; data_qvalid_i in 1; data_qready_o out 1.
REQ-008 SHALL have core response ports: data_pdata_o out DataWidth; data_pwrite_o out 1 (response belongs to a write); data_pvalid_o out 1; data_pready_i in 1.
REQ-009 SHALL have per-port TCDM request ports, each [NrTCDM]: tcdm_req_valid_o out 1; tcdm_req_tgt_addr_o out AddrWidth; tcdm_req_wen_o out 1; tcdm_req_wdata_o out DataWidth; tcdm_req_be_o out StrbWidth; tcdm_req_id_o out IdWidth; tcdm_req_ready_i in 1.
REQ-010 SHALL have per-port TCDM response ports, each [NrTCDM]: tcdm_resp_valid_i in 1; tcdm_resp_rdata_i in DataWidth; tcdm_resp_id_i in IdWidth; tcdm_resp_ready_o out 1.

Function
REQ-011 SHALL route each request to port sel = data_qaddr_i[SelOffset +: SelWidth]; addr, wen, wdata and be are forwarded unchanged to all ports, with valid asserted only on port sel.
REQ-012 SHALL keep ROB state: tail and head pointers (IdWidth bits, wrap modulo RobDepth), a count (IdWidth+1 bits), and per-entry pending, done, write flag and DataWidth data.
REQ-013 SHALL drive tcdm_req_valid_o[sel] = data_qvalid_i & (count != RobDepth) and data_qready_o = (count != RobDepth) & tcdm_req_ready_i[sel]; the full check is independent of same-cycle pops.
REQ-014 SHALL drive tcdm_req_id_o = tail on every port; on an accepted request (valid & ready) it SHALL set pending[tail], store the write flag and increment tail.
REQ-015 SHALL allocate one entry for every request, read or write; the TCDM returns one response per request, carrying rdata (don't-care for writes).
REQ-016 SHALL tie tcdm_resp_ready_o to all ones; a response on port p with id k SHALL write data[k], set done[k] and clear pending[k]; all NrTCDM ports may write distinct entries in the same cycle.
REQ-017 SHALL drive data_pvalid_o = done[head], with data_pdata_o = data[head] and data_pwrite_o = write[head], combinationally from ROB state; the earliest core response is one cycle after the TCDM response.
REQ-018 SHALL, on data_pvalid_o & data_pready_i, clear done[head] and increment head; responses SHALL be returned strictly in request order regardless of TCDM completion order.
REQ-019 SHALL update count = count + accept - pop each cycle; a simultaneous accept and pop SHALL leave count unchanged.
REQ-020 SHALL flag, as a simulation assertion, any response whose id is not pending, and any two same-cycle responses carrying equal ids.
REQ-021 SHALL hold data_pvalid_o stable and data_pdata_o unchanged while data_pvalid_o & !data_pready_i.
REQ-022 SHALL flag, as an elaboration-time fatal, NrTCDM or RobDepth not a power of two, or DataWidth not a multiple of 8.

Reset
REQ-023 SHALL, while rst_ni is low (asynchronously), clear head, tail, count and all pending/done flags; data_pvalid_o=0, all tcdm_req_valid_o=0 only while data_qvalid_i=0, tcdm_resp_ready_o=all ones.
REQ-024 SHALL discard in-flight transactions on a mid-operation reset; TCDM responses arriving after reset deassertion are ignored when not pending (assertion fires).

Verification
REQ-025 SHALL cover: read addr 0x4 (sel=1), TCDM port 1 replies id 0 data 0xDEADBEEF two cycles later -> core pvalid one cycle after, pdata=0xDEADBEEF, pwrite=0.
REQ-026 SHALL cover: reads A (port 0) then B (port 1); B answers first, A answers 3 cycles later -> core sees A then B, pvalid low until A done.
REQ-027 SHALL cover: 8 reads with RobDepth=8 and no responses -> qready=0 on the 9th; one response plus pop -> qready=1 the next cycle.
REQ-028 SHALL cover: all 4 ports respond in the same cycle with ids 0..3 -> four in-order core responses on consecutive cycles with pready=1.
REQ-029 SHALL cover: count=8, pready=1, pvalid=1, qvalid=1 in one cycle -> pop taken, request not accepted (qready=0), count=7 afterwards.
REQ-030 SHALL cover: rst_ni pulsed low with 3 reads outstanding -> pvalid=0, count=0 immediately; a first new request gets id 0.
